bus_master_arbiter: RTL and testbench

BUS_MASTER_ARBITER -- requirements
Module: bus_master_arbiter

---
 rtl/bus_arb_pkg.sv | 13 +
 rtl/bus_rr_pick.sv | 26 ++
 rtl/bus_master_arbiter.sv | 140 ++++++++++++++
 tb/tb_bus_master_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding and default parameters for the bus master arbiter
package bus_arb_pkg;
    localparam int N_MASTERS_DEF      = 4;
    localparam int ADDR_W_DEF         = 16;
    localparam int DATA_W_DEF         = 32;
    localparam int TIMEOUT_CYCLES_DEF = 64;
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_ADDR = 4'b0010,
        S_WAIT = 4'b0100,
        S_DONE = 4'b1000
    } state_t;
endpackage

// File: rtl/bus_rr_pick.sv
// bus_rr_pick: combinational round-robin search starting at pointer p
// Ports: req (requests), p (search start) -> win (one-hot winner), idx (winner index)
module bus_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] p,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx
);
    int j;
    always_comb begin
        win = '0;
        idx = '0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(p) + k;
            j = (j >= N) ? j - N : j;
            if (win == '0 && req[j]) begin
                win[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: round-robin arbiter driving a latched-address system bus (IDLE/ADDR/WAIT/DONE)
// Ports: req/we/addr/wdata per master in; grant/done/rdata/err back to masters;
//        bus_ale_en/bus_read_en/bus_write_en/bus_addr/bus_wdata out, bus_rdata/bus_ready in.
// Option: define ARB_TIMEOUT_EN to add a WAIT watchdog that aborts with err after TIMEOUT_CYCLES.
module bus_master_arbiter import bus_arb_pkg::*; #(
    parameter int N_MASTERS      = N_MASTERS_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS-1:0]        req,
    input  logic [N_MASTERS-1:0]        we,
    input  logic [N_MASTERS*ADDR_W-1:0] addr,
    input  logic [N_MASTERS*DATA_W-1:0] wdata,
    output logic [N_MASTERS-1:0]        grant,
    output logic [N_MASTERS-1:0]        done,
    output logic [DATA_W-1:0]           rdata,
    output logic                        err,
    output logic                        bus_ale_en,
    output logic                        bus_read_en,
    output logic                        bus_write_en,
    output logic [ADDR_W-1:0]           bus_addr,
    output logic [DATA_W-1:0]           bus_wdata,
    input  logic [DATA_W-1:0]           bus_rdata,
    input  logic                        bus_ready
);
    localparam int IW = $clog2(N_MASTERS);
    state_t                state_q, state_d;
    logic [IW-1:0]         p_q, p_d, win_idx;
    logic [N_MASTERS-1:0]  win, grant_q, grant_d, done_q, done_d;
    logic                  seen_low_q, seen_low_d, we_q, we_d;
    logic                  ale_q, ale_d, rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]     bus_wdata_q, bus_wdata_d, rdata_q, rdata_d;
    logic                  finish, abort;
    bus_rr_pick #(.N(N_MASTERS)) u_pick (.req(req), .p(p_q), .win(win), .idx(win_idx));
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;
    assign abort = state_q == S_WAIT && !finish && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign cnt_d = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
    assign err   = err_q;
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
        err_q <= rst ? 1'b0 : abort;
    end
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif
    // A completion needs a low->high bus_ready handshake seen inside WAIT.
    assign finish = state_q == S_WAIT && bus_ready && seen_low_q;
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        grant_d     = grant_q;
        done_d      = '0;
        seen_low_d  = seen_low_q;
        we_d        = we_q;
        ale_d       = 1'b0;
        rd_d        = rd_q;
        wr_d        = wr_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        unique case (state_q)
            S_IDLE: if (|req && bus_ready) begin
                state_d     = S_ADDR;
                grant_d     = win;
                we_d        = we[win_idx];
                ale_d       = 1'b1;
                rd_d        = ~we[win_idx];
                wr_d        = we[win_idx];
                bus_addr_d  = addr[int'(win_idx)*ADDR_W +: ADDR_W];
                bus_wdata_d = wdata[int'(win_idx)*DATA_W +: DATA_W];
                p_d         = (int'(win_idx) == N_MASTERS - 1) ? '0 : win_idx + 1'b1;
            end
            S_ADDR: begin
                state_d    = S_WAIT;
                seen_low_d = 1'b0;
            end
            S_WAIT: begin
                seen_low_d = seen_low_q | ~bus_ready;
                if (finish || abort) begin
                    state_d    = S_DONE;
                    done_d     = grant_q;
                    rd_d       = 1'b0;
                    wr_d       = 1'b0;
                    seen_low_d = 1'b0;
                    rdata_d    = abort ? '0 : (we_q ? rdata_q : bus_rdata);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            seen_low_q  <= 1'b0;
            we_q        <= 1'b0;
            ale_q       <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            seen_low_q  <= seen_low_d;
            we_q        <= we_d;
            ale_q       <= ale_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
        end
    end
    assign grant        = grant_q;
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign bus_ale_en   = ale_q;
    assign bus_read_en  = rd_q;
    assign bus_write_en = wr_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb_bus_master_arbiter: directed self-checking bench for bus_master_arbiter
module tb_bus_master_arbiter;
    logic        clk = 1'b0;
    logic        rst, bus_ready, err, ale, rd, wr;
    logic [3:0]  req, we, grant, done;
    logic [63:0] addr;
    logic [127:0] wdata;
    logic [31:0] rdata, bus_wdata, bus_rdata;
    logic [15:0] bus_addr;
    int tests = 0;
    int fails = 0;

    bus_master_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .grant(grant), .done(done), .rdata(rdata), .err(err),
        .bus_ale_en(ale), .bus_read_en(rd), .bus_write_en(wr),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // From WAIT: bus_ready low one cycle, then high -> DONE, then back to IDLE.
    task automatic to_done(input string tag, input logic [3:0] owner, input logic [31:0] exp_rdata);
        check({tag, "_wait_ale"}, 32'(ale), 32'd0);
        bus_ready = 1'b0;
        tick();
        check({tag, "_no_early_done"}, 32'(done), 32'd0);
        bus_ready = 1'b1;
        tick();
        check({tag, "_done"}, 32'(done), 32'(owner));
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_done_en"}, 32'({rd, wr}), 32'd0);
        tick();
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_grant_clr"}, 32'(grant), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        bus_ready = 1'b1; bus_rdata = '0;
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_en", 32'({ale, rd, wr}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_addr", 32'(bus_addr), 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // single read by master 0
        req = 4'b0001; we = 4'b0000; addr[15:0] = 16'h1234; bus_rdata = 32'hCAFEF00D;
        tick();
        check("rd_grant", 32'(grant), 32'h1);
        check("rd_en", 32'({ale, rd, wr}), 32'b110);
        check("rd_addr", 32'(bus_addr), 32'h1234);
        req = '0;
        tick();
        check("rd_wait_rd", 32'(rd), 32'd1);
        to_done("rd", 4'b0001, 32'hCAFEF00D);

        // single write by master 2; rdata must hold the read value
        req = 4'b0100; we = 4'b0100; addr[47:32] = 16'h0040; wdata[95:64] = 32'hA5A5A5A5;
        bus_rdata = 32'h11111111;
        tick();
        check("wr_grant", 32'(grant), 32'h4);
        check("wr_en", 32'({ale, rd, wr}), 32'b101);
        check("wr_addr", 32'(bus_addr), 32'h0040);
        check("wr_wdata", bus_wdata, 32'hA5A5A5A5);
        req = '0;
        tick();
        check("wr_wait_wr", 32'(wr), 32'd1);
        to_done("wr", 4'b0100, 32'hCAFEF00D);

        // reset brings pointer back to 0, then full contention
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111; we = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            bus_rdata = 32'h10000000 + 32'(k);
            tick();
            check($sformatf("rr_grant%0d", k), 32'(grant), 32'(1 << (k % 4)));
            tick();
            to_done($sformatf("rr%0d", k), 4'(1 << (k % 4)), 32'h10000000 + 32'(k));
        end
        req = '0;

        // master 1 drops req during WAIT; transaction still completes
        req = 4'b0010; bus_rdata = 32'h0BADBEEF;
        tick();
        check("drop_grant", 32'(grant), 32'h2);
        tick();
        req = '0;
        to_done("drop", 4'b0010, 32'h0BADBEEF);

        // reset during WAIT: p would be 2 -> master 0 wins
        req = 4'b0001;
        tick();
        check("rw_grant", 32'(grant), 32'h1);
        tick();
        bus_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rw_en", 32'({ale, rd, wr}), 32'd0);
        check("rw_grant0", 32'(grant), 32'd0);
        check("rw_done0", 32'(done), 32'd0);
        rst = 1'b0; bus_ready = 1'b1; req = '0;
        tick();
        check("rw_no_done", 32'(done), 32'd0);
        // pointer back at 0: with 1001 master 0 wins (p=1 would pick 3)
        req = 4'b1001; bus_rdata = 32'h00C0FFEE;
        tick();
        check("rw_p0", 32'(grant), 32'h1);
        req = '0;
        tick();
        tick();
        check("rw_seen_low_clr", 32'(done), 32'd0);
        to_done("rw", 4'b0001, 32'h00C0FFEE);

`ifdef ARB_TIMEOUT_EN
        req = 4'b0001; we = '0; bus_rdata = 32'hDEADBEEF;
        tick();
        req = '0;
        tick();
        bus_ready = 1'b0;
        for (int k = 0; k < 63; k++) tick();
        check("to_not_yet", 32'(done), 32'd0);
        tick();
        check("to_done", 32'(done), 32'h1);
        check("to_err", 32'(err), 32'd1);
        check("to_rdata", rdata, 32'd0);
        bus_ready = 1'b1;
        tick();
        check("to_err_clr", 32'(err), 32'd0);
        check("to_grant_clr", 32'(grant), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
